assert_one_hot_tracker: RTL and testbench

- Runtime evaluation stage that sits directly upstream of assert_one_hot_cover and alongside the assert/assume checker modules.
- Samples test_expr every clock and flags one-hot violations and X/Z values.
- Accumulates the sticky one_hots_checked bitmask consumed by the cover module.
- Reports sanity and corner coverage events, plus a saturating violation count.

---
 rtl/ovl_one_hot_pkg.sv | 15 +
 rtl/assert_one_hot_tracker_if.sv | 28 ++
 rtl/ovl_onehot_detect.sv | 14 +
 rtl/assert_one_hot_tracker.sv | 109 ++++++++++
 tb/tb_assert_one_hot_tracker.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/ovl_one_hot_pkg.sv
// Shared types for the one-hot tracker family: FSM state encoding and fire vector layout.
package ovl_one_hot_pkg;

   typedef enum logic [1:0] {
      WARMUP        = 2'd0,
      ACTIVE        = 2'd1,
      SATURATED_COV = 2'd2
   } state_e;

   // Fire vector ordering {xcheck, 2state}
   localparam int unsigned FIRE_WIDTH      = 2;
   localparam int unsigned FIRE_2STATE_BIT = 0;
   localparam int unsigned FIRE_XCHECK_BIT = 1;

endpackage

// File: rtl/assert_one_hot_tracker_if.sv
// Sample/result bundle between the checked design and the one-hot tracker.
interface assert_one_hot_tracker_if #(
   parameter int unsigned width     = 1,
   parameter int unsigned CNT_WIDTH = 8
);
   logic                 enable;
   logic                 xzcheck_enable;
   logic [width-1:0]     test_expr;
   logic                 clear_cov;
   logic [width-1:0]     one_hots_checked;
   logic                 fire_2state;
   logic                 fire_xcheck;
   logic                 cover_test_expr_change;
   logic                 cover_all_one_hots_checked;
   logic [CNT_WIDTH-1:0] violation_count;

   modport master (
      output enable, xzcheck_enable, test_expr, clear_cov,
      input  one_hots_checked, fire_2state, fire_xcheck,
             cover_test_expr_change, cover_all_one_hots_checked, violation_count
   );

   modport slave (
      input  enable, xzcheck_enable, test_expr, clear_cov,
      output one_hots_checked, fire_2state, fire_xcheck,
             cover_test_expr_change, cover_all_one_hots_checked, violation_count
   );
endinterface

// File: rtl/ovl_onehot_detect.sv
// Combinational classifier: exactly-one-bit-set, all-zero and X/Z presence.
module ovl_onehot_detect #(
   parameter int unsigned width = 1
) (
   input  logic [width-1:0] expr_i,
   output logic             is_one_hot_o,
   output logic             is_zero_o,
   output logic             has_xz_o
);
   // Clearing the lowest set bit leaves zero only for a single-bit value
   assign is_zero_o    = (expr_i == '0);
   assign is_one_hot_o = !is_zero_o && ((expr_i & (expr_i - width'(1))) == '0);
   assign has_xz_o     = $isunknown(expr_i);
endmodule

// File: rtl/assert_one_hot_tracker.sv
// One-hot runtime tracker: flags violations and X/Z, builds the coverage mask, counts violations.
module assert_one_hot_tracker
   import ovl_one_hot_pkg::*;
#(
   parameter int unsigned width               = 1,
   parameter int unsigned CNT_WIDTH           = 8,
   parameter bit          OVL_COVER_SANITY_ON = 1'b1,
   parameter bit          OVL_COVER_CORNER_ON = 1'b1
) (
   input logic                       clk,
   input logic                       reset,
   assert_one_hot_tracker_if.slave   bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic is_one_hot, is_zero, has_xz;

   ovl_onehot_detect #(.width(width)) u_detect (
      .expr_i       (bus.test_expr),
      .is_one_hot_o (is_one_hot),
      .is_zero_o    (is_zero),
      .has_xz_o     (has_xz)
   );

   state_e                state_q, state_d;
   logic [width-1:0]      mask_q, mask_d;
   logic [width-1:0]      prev_q, prev_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic [FIRE_WIDTH-1:0] fire_q, fire_d;
   logic                  chg_q, chg_d;
   logic                  all_q, all_d;

   logic known, legal, full_d, full_q;

   // A known sample is checked; X/Z samples never update state
   assign known  = bus.enable && !has_xz;
   assign legal  = known && is_one_hot;
   assign full_q = &mask_q;
   assign full_d = &mask_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= WARMUP;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (bus.enable) begin
         unique case (state_q)
            WARMUP:        if (known) state_d = full_d ? SATURATED_COV : ACTIVE;
            ACTIVE:        if (full_d) state_d = SATURATED_COV;
            SATURATED_COV: if (bus.clear_cov && !full_d) state_d = ACTIVE;
            default:       state_d = WARMUP;
         endcase
      end
   end

   always_comb begin
      mask_d  = mask_q;
      prev_d  = prev_q;
      count_d = count_q;
      fire_d  = '0;
      chg_d   = 1'b0;
      all_d   = 1'b0;
      if (bus.enable) begin
         if (bus.clear_cov) mask_d = '0;
         if (legal)         mask_d = mask_d | bus.test_expr;
         if (known)         prev_d = bus.test_expr;
         fire_d[FIRE_2STATE_BIT] = known && (is_zero || !is_one_hot);
         fire_d[FIRE_XCHECK_BIT] = bus.xzcheck_enable && has_xz;
         if (fire_d[FIRE_2STATE_BIT] && (count_q != CNT_MAX))
            count_d = count_q + CNT_WIDTH'(1);
         chg_d = OVL_COVER_SANITY_ON && known && (state_q != WARMUP) &&
                 (bus.test_expr != prev_q);
         // Completion edge: mask newly full, or refilled on the clearing edge
         all_d = OVL_COVER_CORNER_ON && full_d && (!full_q || bus.clear_cov);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask_q  <= '0;
         prev_q  <= '0;
         count_q <= '0;
         fire_q  <= '0;
         chg_q   <= 1'b0;
         all_q   <= 1'b0;
      end else begin
         mask_q  <= mask_d;
         prev_q  <= prev_d;
         count_q <= count_d;
         fire_q  <= fire_d;
         chg_q   <= chg_d;
         all_q   <= all_d;
      end
   end

   assign bus.one_hots_checked           = mask_q;
   assign bus.fire_2state                = fire_q[FIRE_2STATE_BIT];
   assign bus.fire_xcheck                = fire_q[FIRE_XCHECK_BIT];
   assign bus.cover_test_expr_change     = chg_q;
   assign bus.cover_all_one_hots_checked = all_q;
   assign bus.violation_count            = count_q;

endmodule

// File: tb/tb_assert_one_hot_tracker.sv
// Scoreboard bench for assert_one_hot_tracker (width=4, CNT_WIDTH=2) with directed vectors.
module tb_assert_one_hot_tracker;

   localparam int unsigned W  = 4;
   localparam int unsigned CW = 2;

   typedef struct packed {
      logic [W-1:0]  mask;
      logic          f2;
      logic          fx;
      logic          chg;
      logic          all;
      logic [CW-1:0] cnt;
   } exp_t;

   typedef struct {
      exp_t  e;
      string nm;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   sb_t  sb_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   assert_one_hot_tracker_if #(.width(W), .CNT_WIDTH(CW)) bus ();

   assert_one_hot_tracker #(
      .width(W), .CNT_WIDTH(CW), .OVL_COVER_SANITY_ON(1'b1), .OVL_COVER_CORNER_ON(1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t observe();
      exp_t g;
      g.mask = bus.one_hots_checked;
      g.f2   = bus.fire_2state;
      g.fx   = bus.fire_xcheck;
      g.chg  = bus.cover_test_expr_change;
      g.all  = bus.cover_all_one_hots_checked;
      g.cnt  = bus.violation_count;
      return g;
   endfunction

   function automatic void check(input string nm, input exp_t got, input exp_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got mask=%b f2=%b fx=%b chg=%b all=%b cnt=%0d, want mask=%b f2=%b fx=%b chg=%b all=%b cnt=%0d",
                  nm, got.mask, got.f2, got.fx, got.chg, got.all, got.cnt,
                  exp.mask, exp.f2, exp.fx, exp.chg, exp.all, exp.cnt);
      end
   endfunction

   // Monitor: each edge presents the result of the sample issued just before it
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            check(s.nm, observe(), s.e);
         end
      end
   end

   task automatic apply(input logic en, input logic xz, input logic [W-1:0] ex, input logic clr,
                        input logic [W-1:0] m, input logic f2, input logic fx, input logic ch,
                        input logic al, input logic [CW-1:0] cn, input string nm);
      sb_t s;
      @(negedge clk);
      bus.enable         = en;
      bus.xzcheck_enable = xz;
      bus.test_expr      = ex;
      bus.clear_cov      = clr;
      s.e  = '{mask: m, f2: f2, fx: fx, chg: ch, all: al, cnt: cn};
      s.nm = nm;
      sb_q.push_back(s);
   endtask

   task automatic idle();
      @(negedge clk);
      bus.enable    = 1'b0;
      bus.clear_cov = 1'b0;
   endtask

   logic [W-1:0] xv;
   bit           four_state;
   exp_t         zero_e;

   initial begin
      zero_e             = '0;
      xv                 = 4'b01x0;
      four_state         = $isunknown(xv);
      reset              = 1'b1;
      bus.enable         = 1'b0;
      bus.xzcheck_enable = 1'b0;
      bus.test_expr      = '0;
      bus.clear_cov      = 1'b0;
      #3;
      check("reset_state", observe(), zero_e);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // mask growth, single completion pulse
      apply(1, 0, 4'b0001, 0, 4'b0001, 0, 0, 0, 0, 2'd0, "warmup_0001");
      apply(1, 0, 4'b0010, 0, 4'b0011, 0, 0, 1, 0, 2'd0, "grow_0010");
      apply(1, 0, 4'b0100, 0, 4'b0111, 0, 0, 1, 0, 2'd0, "grow_0100");
      apply(1, 0, 4'b1000, 0, 4'b1111, 0, 0, 1, 1, 2'd0, "complete_1000");
      apply(1, 0, 4'b1000, 0, 4'b1111, 0, 0, 0, 0, 2'd0, "no_repulse_a");
      apply(1, 0, 4'b0001, 0, 4'b1111, 0, 0, 1, 0, 2'd0, "no_repulse_b");
      // illegal known values
      apply(1, 0, 4'b0110, 0, 4'b1111, 1, 0, 1, 0, 2'd1, "viol_0110");
      apply(1, 0, 4'b0000, 0, 4'b1111, 1, 0, 1, 0, 2'd2, "viol_0000");
      // X/Z handling, only meaningful where X is representable
      if (four_state) begin
         apply(1, 1, xv, 0, 4'b1111, 0, 1, 0, 0, 2'd2, "xcheck_on");
         apply(1, 0, xv, 0, 4'b1111, 0, 0, 0, 0, 2'd2, "xcheck_off");
      end
      apply(1, 1, 4'b0100, 1, 4'b0100, 0, 0, 1, 0, 2'd2, "clear_with_legal");
      apply(1, 1, 4'b1000, 0, 4'b1100, 0, 0, 1, 0, 2'd2, "active_regrow_a");
      apply(1, 0, 4'b0010, 0, 4'b1110, 0, 0, 1, 0, 2'd2, "active_regrow_b");
      apply(1, 0, 4'b0001, 0, 4'b1111, 0, 0, 1, 1, 2'd2, "recomplete");
      apply(1, 0, 4'b0011, 0, 4'b1111, 1, 0, 1, 0, 2'd3, "sat_a");
      apply(1, 0, 4'b0011, 0, 4'b1111, 1, 0, 0, 0, 2'd3, "sat_b");
      apply(0, 0, 4'b1100, 0, 4'b1111, 0, 0, 0, 0, 2'd3, "disabled_illegal");
      apply(0, 0, 4'b0001, 1, 4'b1111, 0, 0, 0, 0, 2'd3, "disabled_clear");
      apply(1, 0, 4'b0001, 0, 4'b1111, 0, 0, 1, 0, 2'd3, "held_after_disable");

      // asynchronous reset between edges
      @(negedge clk);
      bus.enable = 1'b0;
      #2 reset = 1'b1;
      #1 check("async_reset", observe(), zero_e);
      @(negedge clk);
      reset = 1'b0;

      // saturation from a fresh count; warmup suppresses change cover
      apply(1, 0, 4'b0011, 0, 4'b0000, 1, 0, 0, 0, 2'd1, "cnt_1");
      apply(1, 0, 4'b0011, 0, 4'b0000, 1, 0, 0, 0, 2'd2, "cnt_2");
      apply(1, 0, 4'b0011, 0, 4'b0000, 1, 0, 0, 0, 2'd3, "cnt_3");
      apply(1, 0, 4'b0011, 0, 4'b0000, 1, 0, 0, 0, 2'd3, "cnt_hold_a");
      apply(1, 0, 4'b0011, 0, 4'b0000, 1, 0, 0, 0, 2'd3, "cnt_hold_b");
      apply(1, 0, 4'b0100, 0, 4'b0100, 0, 0, 1, 0, 2'd3, "legal_after");
      apply(0, 0, 4'b0000, 0, 4'b0100, 0, 0, 0, 0, 2'd3, "disabled_zero");
      idle();

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d expected results still pending, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
